// File: rtl/bitstream_word_writer_pkg.sv
// Shared types and constants for the bitstream word writer.
// Holds the state enum, the word packing width and the default stream length.
package bitstream_pkg;

    localparam int BYTES_PER_WORD    = 4;
    localparam int MAX_BYTES_DEFAULT = 16384;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SETUP,
        STROBE,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/bitstream_word_writer_if.sv
// Byte-stream valid/ready channel feeding the bitstream word writer.
interface bitstream_word_writer_if;

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/bitstream_byte_packer.sv
// Big-endian byte-to-word packer: first accepted byte lands in word[31:24].
// word_done pulses combinationally on the 4th accept so the caller can latch word.
module bitstream_byte_packer
    import bitstream_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] shift_reg;
    logic [1:0]  byte_idx;

    // byte_idx wraps 3 -> 0 on the completing accept, ready for the next word.
    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            shift_reg <= '0;
            byte_idx  <= '0;
        end else if (accept) begin
            shift_reg <= {shift_reg[15:0], byte_data};
            byte_idx  <= byte_idx + 2'd1;
        end
    end

    assign word      = {shift_reg, byte_data};
    assign word_done = accept && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/bitstream_word_writer.sv
// eFPGA self-write loader: packs bytes into words, holds each for a setup interval,
// strobes it, then idles for a gap. Checksum register is built only with BITSTREAM_CSUM_EN.
module bitstream_word_writer
    import bitstream_pkg::*;
#(
    parameter int MAX_BYTES    = MAX_BYTES_DEFAULT,
    parameter int SETUP_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int WCNT_W       = $clog2(MAX_BYTES / 4 + 1)
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    bitstream_word_writer_if.slave    bus,
    output logic [31:0]               SelfWriteData,
    output logic                      SelfWriteStrobe,
    output logic                      busy,
    output logic                      done,
    output logic [WCNT_W-1:0]         words_written,
    output logic [31:0]               csum
);

    // state   | meaning
    // IDLE    | waiting for start after reset
    // COLLECT | accepting bytes until a word is complete
    // SETUP   | SelfWriteData held stable before the strobe
    // STROBE  | single-cycle SelfWriteStrobe
    // GAP     | idle spacing before the next word
    // DONE    | all words written, waiting for a restart

    localparam int TMR_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0]  SETUP_LOAD  = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD    = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [WCNT_W-1:0] TOTAL_WORDS = WCNT_W'(MAX_BYTES / BYTES_PER_WORD);

    state_t            state, state_next;
    logic [TMR_W-1:0]  timer, timer_next;
    logic              ready_q;
    logic              clear;
    logic              accept;
    logic [31:0]       word;
    logic              word_done;

    assign accept         = ready_q && bus.byte_valid;
    assign bus.byte_ready = ready_q;

    bitstream_byte_packer u_packer (
        .CLK       (CLK),
        .reset     (reset),
        .clear     (clear),
        .accept    (accept),
        .byte_data (bus.byte_data),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_next = state;
        timer_next = timer;
        clear      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = COLLECT;
                    clear      = 1'b1;
                end
            end
            COLLECT: begin
                if (word_done) begin
                    state_next = SETUP;
                    timer_next = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (timer == '0) state_next = STROBE;
                else             timer_next = timer - TMR_W'(1);
            end
            STROBE: begin
                // With no gap the completion test happens here, before the count updates.
                if (GAP_CYCLES == 0) begin
                    state_next = (words_written == TOTAL_WORDS - WCNT_W'(1)) ? DONE : COLLECT;
                end else begin
                    state_next = GAP;
                    timer_next = GAP_LOAD;
                end
            end
            GAP: begin
                if (timer == '0) state_next = (words_written == TOTAL_WORDS) ? DONE : COLLECT;
                else             timer_next = timer - TMR_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            ready_q         <= 1'b0;
            SelfWriteData   <= '0;
            SelfWriteStrobe <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            words_written   <= '0;
        end else begin
            state           <= state_next;
            timer           <= timer_next;
            ready_q         <= (state_next == COLLECT);
            SelfWriteStrobe <= (state_next == STROBE);
            busy            <= (state_next inside {COLLECT, SETUP, STROBE, GAP});
            done            <= (state_next == DONE);
            if (word_done) SelfWriteData <= word;
            if (clear)                 words_written <= '0;
            else if (state == STROBE)  words_written <= words_written + WCNT_W'(1);
        end
    end

`ifdef BITSTREAM_CSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge CLK) begin
        if (reset || clear)       csum_q <= '0;
        else if (state == STROBE) csum_q <= csum_q ^ SelfWriteData;
    end

    assign csum = csum_q;
`else
    assign csum = 32'h0;
`endif

endmodule
